hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control-signal carrier and hazard unit for a 5-stage core.
//
// Carries RegWrite/MemtoReg/PCSrc from D through E, M and W. It also produces
// operand-forwarding selects, load-use stall, PC-write/branch flushes, and two
// saturating event counters.
//
// Ports
//   clk, reset                         clock; synchronous active-high reset
//   RegWriteD, MemtoRegD, PCSrcD       decoded control entering E
//   CondExE                            condition check for the instruction in E
//   BranchTakenE                       branch resolved taken in E
//   Match_1E_M/_W, Match_2E_M/_W       E source reg equals M/W destination
//   Match_12D_E                        D source reg equals E destination
//   RegWriteW, MemtoRegW, PCSrcW       W-stage control
//   ForwardAE, ForwardBE               00 = register file, 01 = ResultW, 10 = ALUOutM
//   StallF, StallD, FlushD, FlushE     hazard controls
//   LdStallCnt, FlushCnt               saturating counts of load stalls / D flushes
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  input  logic             Match_1E_M,
  input  logic             Match_1E_W,
  input  logic             Match_2E_M,
  input  logic             Match_2E_W,
  input  logic             Match_12D_E,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic             PCSrcW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] LdStallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic RegWriteE, MemtoRegE, PCSrcE;
  logic RegWriteM, MemtoRegM, PCSrcM;
  logic RegWriteEg, PCSrcEg;
  logic ldr_stall, pc_wr_pending;

  // A failed condition kills the instruction's architectural effects beyond E.
  assign RegWriteEg = RegWriteE & CondExE;
  assign PCSrcEg    = PCSrcE & CondExE;

  always_comb begin
    ldr_stall     = 1'b0;
    pc_wr_pending = 1'b0;
    ForwardAE     = 2'b00;
    ForwardBE     = 2'b00;
    StallF        = 1'b0;
    StallD        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    // Everything quiet while in reset so nothing in flight is acted on.
    if (!reset) begin
      ldr_stall     = Match_12D_E & MemtoRegE & RegWriteE;
      pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

      // M stage holds the younger result, so it wins over W.
      if (Match_1E_M && RegWriteM)      ForwardAE = 2'b10;
      else if (Match_1E_W && RegWriteW) ForwardAE = 2'b01;

      if (Match_2E_M && RegWriteM)      ForwardBE = 2'b10;
      else if (Match_2E_W && RegWriteW) ForwardBE = 2'b01;

      StallF = ldr_stall | pc_wr_pending;
      StallD = ldr_stall;
      FlushD = pc_wr_pending | PCSrcW | BranchTakenE;
      FlushE = ldr_stall | BranchTakenE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteE  <= 1'b0;
      MemtoRegE  <= 1'b0;
      PCSrcE     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      PCSrcW     <= 1'b0;
      LdStallCnt <= '0;
      FlushCnt   <= '0;
    end else begin
      if (FlushE) begin
        RegWriteE <= 1'b0;
        MemtoRegE <= 1'b0;
        PCSrcE    <= 1'b0;
      end else begin
        RegWriteE <= RegWriteD;
        MemtoRegE <= MemtoRegD;
        PCSrcE    <= PCSrcD;
      end

      RegWriteM <= RegWriteEg;
      MemtoRegM <= MemtoRegE;
      PCSrcM    <= PCSrcEg;

      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      PCSrcW    <= PCSrcM;

      // Saturate at all-ones rather than wrapping.
      if (ldr_stall && !(&LdStallCnt)) LdStallCnt <= LdStallCnt + CNT_W'(1);
      if (FlushD && !(&FlushCnt))      FlushCnt   <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE;
  logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic        RegWriteW, MemtoRegW, PCSrcW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] LdStallCnt, FlushCnt;

  int tests = 0;
  int fails = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .PCSrcD       (PCSrcD),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .Match_1E_M   (Match_1E_M),
    .Match_1E_W   (Match_1E_W),
    .Match_2E_M   (Match_2E_M),
    .Match_2E_W   (Match_2E_W),
    .Match_12D_E  (Match_12D_E),
    .RegWriteW    (RegWriteW),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .LdStallCnt   (LdStallCnt),
    .FlushCnt     (FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    RegWriteD = 0; MemtoRegD = 0; PCSrcD = 0; CondExE = 1; BranchTakenE = 0;
    Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0; Match_12D_E = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    tick();
    tick();
    // Reset state
    check("rst_RegWriteW", 16'(RegWriteW), 16'd0);
    check("rst_PCSrcW", 16'(PCSrcW), 16'd0);
    check("rst_LdStallCnt", LdStallCnt, 16'd0);
    check("rst_FlushCnt", FlushCnt, 16'd0);
    reset = 0;

    // Forward priority: two writers in flight -> M and W both write
    RegWriteD = 1;
    tick();
    tick();
    RegWriteD = 0;
    tick();                       // M=1, W=1
    Match_1E_M = 1; Match_1E_W = 1; Match_2E_W = 1;
    settle();
    check("fwdA_M_prio", 16'(ForwardAE), 16'd2);
    check("fwdB_W_only", 16'(ForwardBE), 16'd1);
    Match_1E_M = 0;
    settle();
    check("fwdA_W", 16'(ForwardAE), 16'd1);
    tick();                       // M=0, W=1
    Match_1E_M = 1;
    settle();
    check("fwdA_Mnowr", 16'(ForwardAE), 16'd1);
    tick();                       // W=0
    settle();
    check("fwdA_none", 16'(ForwardAE), 16'd0);
    check("fwdB_none", 16'(ForwardBE), 16'd0);
    idle_inputs();

    // Load-use stall
    do_reset();
    RegWriteD = 1; MemtoRegD = 1;
    tick();                       // load in E
    RegWriteD = 0; MemtoRegD = 0; Match_12D_E = 1;
    settle();
    check("ld_StallF", 16'(StallF), 16'd1);
    check("ld_StallD", 16'(StallD), 16'd1);
    check("ld_FlushE", 16'(FlushE), 16'd1);
    check("ld_cnt0", LdStallCnt, 16'd0);
    tick();                       // bubble in E, load in M
    settle();
    check("ld_StallF_off", 16'(StallF), 16'd0);
    check("ld_cnt1", LdStallCnt, 16'd1);
    Match_12D_E = 0;
    tick();                       // load in W
    check("ld_W_load", 16'(RegWriteW), 16'd1);
    check("ld_W_memtoreg", 16'(MemtoRegW), 16'd1);
    tick();                       // bubble in W
    check("ld_W_bubble", 16'(RegWriteW), 16'd0);

    // PC write with condition pass: D, E, M, W cycles
    do_reset();
    PCSrcD = 1;
    settle();
    check("pc_D_StallF", 16'(StallF), 16'd1);
    check("pc_D_FlushD", 16'(FlushD), 16'd1);
    tick();
    PCSrcD = 0;
    settle();
    check("pc_E_StallF", 16'(StallF), 16'd1);
    check("pc_E_FlushD", 16'(FlushD), 16'd1);
    tick();
    check("pc_M_StallF", 16'(StallF), 16'd1);
    check("pc_M_FlushD", 16'(FlushD), 16'd1);
    tick();
    check("pc_W_PCSrcW", 16'(PCSrcW), 16'd1);
    check("pc_W_FlushD", 16'(FlushD), 16'd1);
    tick();
    check("pc_done_FlushD", 16'(FlushD), 16'd0);
    check("pc_FlushCnt", FlushCnt, 16'd4);

    // PC write with condition fail
    do_reset();
    PCSrcD = 1;
    tick();
    PCSrcD = 0; CondExE = 0;
    settle();
    check("cf_E_StallF", 16'(StallF), 16'd1);
    tick();
    CondExE = 1;
    settle();
    check("cf_StallF_drop", 16'(StallF), 16'd0);
    tick();
    check("cf_PCSrcW", 16'(PCSrcW), 16'd0);

    // Branch taken: flushes E, no fetch stall
    do_reset();
    RegWriteD = 1;
    tick();
    BranchTakenE = 1;
    settle();
    check("br_FlushD", 16'(FlushD), 16'd1);
    check("br_FlushE", 16'(FlushE), 16'd1);
    check("br_StallF", 16'(StallF), 16'd0);
    tick();
    BranchTakenE = 0; RegWriteD = 0;
    settle();
    check("br_FlushE_off", 16'(FlushE), 16'd0);
    tick();
    check("br_W_older", 16'(RegWriteW), 16'd1);
    tick();
    check("br_W_flushed", 16'(RegWriteW), 16'd0);

    // Load-use and branch together
    do_reset();
    RegWriteD = 1; MemtoRegD = 1;
    tick();
    RegWriteD = 0; MemtoRegD = 0; Match_12D_E = 1; BranchTakenE = 1;
    settle();
    check("both_hz", {12'd0, StallF, StallD, FlushD, FlushE}, 16'hF);
    tick();
    BranchTakenE = 0;
    settle();
    check("both_E_cleared", 16'(StallD), 16'd0);

    // Reset mid-operation discards pending work
    do_reset();
    RegWriteD = 1; MemtoRegD = 1; PCSrcD = 1;
    tick();
    Match_12D_E = 1; BranchTakenE = 1; Match_1E_W = 1; Match_1E_M = 1;
    reset = 1;
    settle();
    check("rst_hz_forced", {12'd0, StallF, StallD, FlushD, FlushE}, 16'h0);
    check("rst_fwdA", 16'(ForwardAE), 16'd0);
    tick();
    reset = 0;
    idle_inputs();
    settle();
    check("post_rst_hz", {12'd0, StallF, StallD, FlushD, FlushE}, 16'h0);
    tick();
    tick();
    check("post_rst_PCSrcW", 16'(PCSrcW), 16'd0);
    check("post_rst_RegWriteW", 16'(RegWriteW), 16'd0);

    // Counter saturation, then reset
    do_reset();
    PCSrcD = 1;
    for (int i = 0; i < 70000; i++) tick();
    check("sat_FlushCnt", FlushCnt, 16'hFFFF);
    tick();
    tick();
    check("sat_hold", FlushCnt, 16'hFFFF);
    reset = 1;
    settle();
    check("sat_rst_StallF", 16'(StallF), 16'd0);
    check("sat_rst_FlushD", 16'(FlushD), 16'd0);
    tick();
    check("sat_rst_FlushCnt", FlushCnt, 16'd0);
    check("sat_rst_LdCnt", LdStallCnt, 16'd0);
    check("sat_rst_PCSrcW", 16'(PCSrcW), 16'd0);
    reset = 0;
    PCSrcD = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
